sfp_link_sequencer: RTL and testbench
=====================================

Name: sfp_link_sequencer

Overview:
Bring-up and recovery controller for the 10G SFP Ethernet subsystem: one shared 156.25 MHz QPLL feeding NUM_PORTS GT channels and their 10G MACs.
- Sequences QPLL reset and lock, then per-port GT TX/RX reset, PCS block-lock qualification and MAC reset release.
- Monitors lock loss and re-runs the affected stage.
- Runs on sys_clk beside the system reset generator; all GT status inputs are asynchronous and are synchronized internally.

Parameters:
NUM_PORTS, 2, number of SFP ports sharing the QPLL
QPLL_RST_CYCLES, 128, qpll_reset pulse width in sys_clk cycles
GT_RST_CYCLES, 64, GT TX/RX reset pulse width in cycles
MAC_RST_CYCLES, 16, cycles mac_rstn is held low after block lock
LOCK_TIMEOUT, 100000, max cycles waiting for qpll_lock, gt_reset_done or block_lock
DEBOUNCE, 1024, consecutive block_lock-low cycles that count as link loss

Ports:
sys_clk  in  1  system clock (100 MHz)
sys_rstn  in  1  asynchronous active-low reset
enable  in  1  sequencer run; 0 forces everything into reset
qpll_lock  in  1  QPLL lock, asynchronous
qpll_reset  out  1  QPLL reset, active high
qpll_ready  out  1  QPLL locked and qualified
gt_reset_done  in  NUM_PORTS  per-port GT reset done, asynchronous
block_lock  in  NUM_PORTS  per-port PCS block lock, asynchronous
gt_tx_reset  out  NUM_PORTS  per-port GT TX reset, active high
gt_rx_reset  out  NUM_PORTS  per-port GT RX reset, active high
mac_rstn  out  NUM_PORTS  per-port MAC reset, active low
link_up  out  NUM_PORTS  per-port link qualified
qpll_fail_cnt  out  8  QPLL lock-timeout count, saturating
link_drop_cnt  out  8*NUM_PORTS  per-port link-loss count, saturating; port i in bits [8i+7:8i]

Behaviour:
- One clock domain: sys_clk. Reset is asynchronous, active-low: sys_rstn.
- Reset values: qpll_reset=1, gt_tx_reset=gt_rx_reset=all 1, mac_rstn=0, link_up=0, qpll_ready=0, counters 0, all FSMs in their first state.
- All outputs are registered (Moore, decoded from state registers).
- qpll_lock, gt_reset_done and block_lock each pass through a 2-flop synchronizer (the _s signals below); these flops also reset to 0.
- Global FSM:
  - G_IDLE: qpll_reset=1. enable=1 -> G_QPLL_RST.
  - G_QPLL_RST: qpll_reset=1 for exactly QPLL_RST_CYCLES, then G_WAIT_LOCK.
  - G_WAIT_LOCK: qpll_reset=0. qpll_lock_s=1 -> G_READY. Timer reaching LOCK_TIMEOUT -> qpll_fail_cnt++ (saturate at 255), back to G_QPLL_RST.
  - G_READY: qpll_ready=1. qpll_lock_s=0 -> G_QPLL_RST.
  - enable=0 in any state -> G_IDLE on the next edge; this has priority over all other transitions.
- qpll_ready rises on the 3rd sys_clk edge after qpll_lock is high in G_WAIT_LOCK (2 sync flops + state register).
- Per-port FSM, one independent copy per port:
  - P_RESET: both GT resets=1, mac_rstn=0. qpll_ready=1 -> P_GT_RST.
  - P_GT_RST: both GT resets=1 for GT_RST_CYCLES, then P_WAIT_DONE.
  - P_WAIT_DONE: GT resets=0. gt_reset_done_s=1 -> P_WAIT_LOCK. Timeout -> P_GT_RST.
  - P_WAIT_LOCK: mac_rstn=0. block_lock_s=1 -> P_MAC_RST. Timeout -> P_GT_RST.
  - P_MAC_RST: mac_rstn=0 for MAC_RST_CYCLES, then P_UP. If block_lock_s falls here -> P_WAIT_LOCK; no count.
  - P_UP: mac_rstn=1, link_up=1. block_lock_s low for DEBOUNCE consecutive cycles -> link_drop_cnt[i]++ (saturating) and P_WAIT_LOCK. Shorter low glitches reset the debounce counter and are ignored.
  - qpll_ready=0 sends the port to P_RESET next edge from any state, with priority over all other transitions.
- Timers: each FSM has one down-counter, reloaded on every state entry, width $clog2(max param + 1). Timeout fires when the counter reaches 0. The lock condition is checked before the timeout in the same cycle, so lock wins.
- Ports never interact. A timeout or link drop on one port does not disturb the other.
- Counters change only on the stated events. They clear only on sys_rstn, not on enable=0.

Decomposition:
- Package sfp_seq_pkg: global and port state encodings (G_*, P_*) and the counter width function.
- Sub-module sfp_port_seq: per-port FSM, timer, debounce and drop counter. Instantiated NUM_PORTS times via generate.
- Top sfp_link_sequencer: synchronizers, global FSM, qpll_fail_cnt.

Test Plan:
Use QPLL_RST_CYCLES=4, GT_RST_CYCLES=4, MAC_RST_CYCLES=4, LOCK_TIMEOUT=64, DEBOUNCE=8 throughout.
1. Nominal bring-up: enable=1, qpll_lock at cycle 10, gt_reset_done 5 cycles after GT reset release, block_lock 10 cycles later -> qpll_reset low after 4 cycles, qpll_ready 3 edges after lock, both ports link_up=1, mac_rstn=1, all counters 0.
2. QPLL timeout: qpll_lock held 0 -> qpll_reset re-pulses every 4+64 cycles and qpll_fail_cnt counts 1,2,3. Lock then applied -> normal bring-up completes.
3. Debounce: port 0 up, block_lock[0] low for 7 cycles -> link_up stays 1. Then low for 8 cycles -> link_up[0]=0, link_drop_cnt[0]=1, port 1 unaffected. Lock restored -> link_up[0]=1 after MAC_RST_CYCLES + sync latency.
4. QPLL loss: both ports up, qpll_lock drops -> qpll_ready=0 within 3 edges, then all gt resets=1, mac_rstn=0, link_up=0 the next edge. Full re-sequence follows.
5. Saturation: 300 forced link drops on port 1 -> link_drop_cnt[1] stays at 255.
6. Mid-operation control: enable deasserted during P_MAC_RST -> G_IDLE next edge, reset-value outputs, counters kept. sys_rstn asserted asynchronously mid-sequence -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sfp_seq_pkg.sv
// Shared state encodings and sizing helpers for the SFP link sequencer.
package sfp_seq_pkg;

    typedef enum logic [1:0] {
        G_IDLE,
        G_QPLL_RST,
        G_WAIT_LOCK,
        G_READY
    } g_state_t;

    typedef enum logic [2:0] {
        P_RESET,
        P_GT_RST,
        P_WAIT_DONE,
        P_WAIT_LOCK,
        P_MAC_RST,
        P_UP
    } p_state_t;

    localparam logic [7:0] CNT_SAT = 8'hFF;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a down-counter that must be able to hold max_val.
    function automatic int cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sfp_port_seq.sv
// Per-port GT/PCS/MAC bring-up FSM with block-lock debounce and link-drop counter.
module sfp_port_seq
    import sfp_seq_pkg::*;
#(
    parameter int GT_RST_CYCLES  = 64,
    parameter int MAC_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int DEBOUNCE       = 1024
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       qpll_ready,
    input  logic       gt_reset_done_s,
    input  logic       block_lock_s,
    output logic       gt_tx_reset,
    output logic       gt_rx_reset,
    output logic       mac_rstn,
    output logic       link_up,
    output logic [7:0] link_drop_cnt
);

    localparam int P_TW = cnt_width(max2(max2(GT_RST_CYCLES, MAC_RST_CYCLES), LOCK_TIMEOUT));
    localparam int D_W  = cnt_width(DEBOUNCE);
    localparam logic [D_W-1:0] DEB_LAST = D_W'(DEBOUNCE - 1);

    p_state_t        p_state;
    p_state_t        p_next;
    logic [P_TW-1:0] p_timer;
    logic [D_W-1:0]  deb_cnt;
    logic            drop_evt;

    function automatic logic [P_TW-1:0] p_reload(input p_state_t s);
        case (s)
            P_GT_RST:    return P_TW'(GT_RST_CYCLES - 1);
            P_WAIT_DONE: return P_TW'(LOCK_TIMEOUT - 1);
            P_WAIT_LOCK: return P_TW'(LOCK_TIMEOUT - 1);
            P_MAC_RST:   return P_TW'(MAC_RST_CYCLES - 1);
            default:     return '0;
        endcase
    endfunction

    // Lock conditions are tested ahead of the timer so a late lock still wins.
    always_comb begin
        p_next   = p_state;
        drop_evt = 1'b0;
        if (!qpll_ready) begin
            p_next = P_RESET;
        end else begin
            case (p_state)
                P_RESET:     p_next = P_GT_RST;
                P_GT_RST:    if (p_timer == '0) p_next = P_WAIT_DONE;
                P_WAIT_DONE: begin
                    if (gt_reset_done_s)     p_next = P_WAIT_LOCK;
                    else if (p_timer == '0)  p_next = P_GT_RST;
                end
                P_WAIT_LOCK: begin
                    if (block_lock_s)        p_next = P_MAC_RST;
                    else if (p_timer == '0)  p_next = P_GT_RST;
                end
                P_MAC_RST: begin
                    if (!block_lock_s)       p_next = P_WAIT_LOCK;
                    else if (p_timer == '0)  p_next = P_UP;
                end
                P_UP: begin
                    if (!block_lock_s && deb_cnt == DEB_LAST) begin
                        p_next   = P_WAIT_LOCK;
                        drop_evt = 1'b1;
                    end
                end
                default:     p_next = P_RESET;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            p_state       <= P_RESET;
            p_timer       <= '0;
            deb_cnt       <= '0;
            gt_tx_reset   <= 1'b1;
            gt_rx_reset   <= 1'b1;
            mac_rstn      <= 1'b0;
            link_up       <= 1'b0;
            link_drop_cnt <= '0;
        end else begin
            p_state <= p_next;
            if (p_next != p_state) begin
                p_timer <= p_reload(p_next);
            end else if (p_timer != '0) begin
                p_timer <= p_timer - P_TW'(1);
            end
            if (p_state == P_UP && p_next == P_UP && !block_lock_s) begin
                deb_cnt <= deb_cnt + D_W'(1);
            end else begin
                deb_cnt <= '0;
            end
            gt_tx_reset <= (p_next == P_RESET) || (p_next == P_GT_RST);
            gt_rx_reset <= (p_next == P_RESET) || (p_next == P_GT_RST);
            mac_rstn    <= (p_next == P_UP);
            link_up     <= (p_next == P_UP);
            if (drop_evt && link_drop_cnt != CNT_SAT) begin
                link_drop_cnt <= link_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sfp_link_sequencer.sv
// 10G SFP subsystem bring-up: input synchronizers, shared QPLL sequencing and per-port sequencers.
module sfp_link_sequencer
    import sfp_seq_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int QPLL_RST_CYCLES = 128,
    parameter int GT_RST_CYCLES   = 64,
    parameter int MAC_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int DEBOUNCE        = 1024
) (
    input  logic                   sys_clk,
    input  logic                   sys_rstn,
    input  logic                   enable,
    input  logic                   qpll_lock,
    output logic                   qpll_reset,
    output logic                   qpll_ready,
    input  logic [NUM_PORTS-1:0]   gt_reset_done,
    input  logic [NUM_PORTS-1:0]   block_lock,
    output logic [NUM_PORTS-1:0]   gt_tx_reset,
    output logic [NUM_PORTS-1:0]   gt_rx_reset,
    output logic [NUM_PORTS-1:0]   mac_rstn,
    output logic [NUM_PORTS-1:0]   link_up,
    output logic [7:0]             qpll_fail_cnt,
    output logic [8*NUM_PORTS-1:0] link_drop_cnt
);

    localparam int G_TW = cnt_width(max2(QPLL_RST_CYCLES, LOCK_TIMEOUT));

    logic [1:0]           qpll_lock_sync;
    logic                 qpll_lock_s;
    logic [NUM_PORTS-1:0] done_meta;
    logic [NUM_PORTS-1:0] done_s;
    logic [NUM_PORTS-1:0] lock_meta;
    logic [NUM_PORTS-1:0] lock_s;

    g_state_t        g_state;
    g_state_t        g_next;
    logic [G_TW-1:0] g_timer;
    logic            g_timeout_evt;

    // All GT status lines are asynchronous to sys_clk.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            qpll_lock_sync <= '0;
            done_meta      <= '0;
            done_s         <= '0;
            lock_meta      <= '0;
            lock_s         <= '0;
        end else begin
            qpll_lock_sync <= {qpll_lock_sync[0], qpll_lock};
            done_meta      <= gt_reset_done;
            done_s         <= done_meta;
            lock_meta      <= block_lock;
            lock_s         <= lock_meta;
        end
    end

    assign qpll_lock_s = qpll_lock_sync[1];

    function automatic logic [G_TW-1:0] g_reload(input g_state_t s);
        case (s)
            G_QPLL_RST:  return G_TW'(QPLL_RST_CYCLES - 1);
            G_WAIT_LOCK: return G_TW'(LOCK_TIMEOUT - 1);
            default:     return '0;
        endcase
    endfunction

    always_comb begin
        g_next        = g_state;
        g_timeout_evt = 1'b0;
        if (!enable) begin
            g_next = G_IDLE;
        end else begin
            case (g_state)
                G_IDLE:      g_next = G_QPLL_RST;
                G_QPLL_RST:  if (g_timer == '0) g_next = G_WAIT_LOCK;
                G_WAIT_LOCK: begin
                    if (qpll_lock_s) begin
                        g_next = G_READY;
                    end else if (g_timer == '0) begin
                        g_next        = G_QPLL_RST;
                        g_timeout_evt = 1'b1;
                    end
                end
                G_READY:     if (!qpll_lock_s) g_next = G_QPLL_RST;
                default:     g_next = G_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            g_state       <= G_IDLE;
            g_timer       <= '0;
            qpll_reset    <= 1'b1;
            qpll_ready    <= 1'b0;
            qpll_fail_cnt <= '0;
        end else begin
            g_state <= g_next;
            if (g_next != g_state) begin
                g_timer <= g_reload(g_next);
            end else if (g_timer != '0) begin
                g_timer <= g_timer - G_TW'(1);
            end
            qpll_reset <= (g_next == G_IDLE) || (g_next == G_QPLL_RST);
            qpll_ready <= (g_next == G_READY);
            if (g_timeout_evt && qpll_fail_cnt != CNT_SAT) begin
                qpll_fail_cnt <= qpll_fail_cnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sfp_port_seq #(
            .GT_RST_CYCLES  (GT_RST_CYCLES),
            .MAC_RST_CYCLES (MAC_RST_CYCLES),
            .LOCK_TIMEOUT   (LOCK_TIMEOUT),
            .DEBOUNCE       (DEBOUNCE)
        ) u_port (
            .sys_clk         (sys_clk),
            .sys_rstn        (sys_rstn),
            .qpll_ready      (qpll_ready),
            .gt_reset_done_s (done_s[i]),
            .block_lock_s    (lock_s[i]),
            .gt_tx_reset     (gt_tx_reset[i]),
            .gt_rx_reset     (gt_rx_reset[i]),
            .mac_rstn        (mac_rstn[i]),
            .link_up         (link_up[i]),
            .link_drop_cnt   (link_drop_cnt[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_sfp_link_sequencer.sv
// Self-checking bench for sfp_link_sequencer: randomized link/QPLL events against a timing/count model.
module tb_sfp_link_sequencer;

    localparam int QRST   = 4;
    localparam int GTRST  = 4;
    localparam int MACRST = 4;
    localparam int LTO    = 64;
    localparam int DEB    = 8;
    localparam int SYNC   = 2;
    localparam int GT_DONE_DLY = 5;
    localparam int PCS_DLY     = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        enable = 1'b0;
    logic        qpll_lock = 1'b0;
    logic [1:0]  gt_reset_done = '0;
    logic [1:0]  block_lock = '0;
    logic        qpll_reset;
    logic        qpll_ready;
    logic [1:0]  gt_tx_reset;
    logic [1:0]  gt_rx_reset;
    logic [1:0]  mac_rstn;
    logic [1:0]  link_up;
    logic [7:0]  qpll_fail_cnt;
    logic [15:0] link_drop_cnt;

    logic [1:0]  link_ok = '0;
    int          done_cnt[2] = '{0, 0};
    int          pcs_cnt[2] = '{0, 0};
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          exp_fail = 0;
    int          exp_drop[2] = '{0, 0};

    sfp_link_sequencer #(
        .NUM_PORTS       (2),
        .QPLL_RST_CYCLES (QRST),
        .GT_RST_CYCLES   (GTRST),
        .MAC_RST_CYCLES  (MACRST),
        .LOCK_TIMEOUT    (LTO),
        .DEBOUNCE        (DEB)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .enable        (enable),
        .qpll_lock     (qpll_lock),
        .qpll_reset    (qpll_reset),
        .qpll_ready    (qpll_ready),
        .gt_reset_done (gt_reset_done),
        .block_lock    (block_lock),
        .gt_tx_reset   (gt_tx_reset),
        .gt_rx_reset   (gt_rx_reset),
        .mac_rstn      (mac_rstn),
        .link_up       (link_up),
        .qpll_fail_cnt (qpll_fail_cnt),
        .link_drop_cnt (link_drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural GT/PCS: reset_done a few cycles after reset release, block lock later while the fiber is good.
    always @(negedge sys_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (gt_tx_reset[p] || gt_rx_reset[p]) begin
                done_cnt[p] = 0;
                pcs_cnt[p]  = 0;
            end else if (done_cnt[p] < GT_DONE_DLY) begin
                done_cnt[p] = done_cnt[p] + 1;
            end else if (pcs_cnt[p] < PCS_DLY) begin
                pcs_cnt[p] = pcs_cnt[p] + 1;
            end
            gt_reset_done[p] = (done_cnt[p] == GT_DONE_DLY);
            block_lock[p]    = (pcs_cnt[p] == PCS_DLY) && link_ok[p];
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic qlock, input logic [1:0] lok);
        enable    = en;
        qpll_lock = qlock;
        link_ok   = lok;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] drop_of(input int p);
        return link_drop_cnt[8*p +: 8];
    endfunction

    // Port 0 link_up, t ticks after the fiber goes bad for L ticks.
    function automatic logic exp_link0(input int t, input int L);
        if (L < DEB) return 1'b1;
        if (t < SYNC + DEB) return 1'b1;
        return (t >= L + SYNC + 1 + MACRST);
    endfunction

    task automatic check_counters(input string tag);
        checkOutput({tag, "_fail"}, 32'(qpll_fail_cnt), 32'(exp_fail));
        checkOutput({tag, "_drop0"}, 32'(drop_of(0)), 32'(exp_drop[0]));
        checkOutput({tag, "_drop1"}, 32'(drop_of(1)), 32'(exp_drop[1]));
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_qrst"}, 32'(qpll_reset), 32'd1);
        checkOutput({tag, "_ready"}, 32'(qpll_ready), 32'd0);
        checkOutput({tag, "_ports"}, 32'({gt_tx_reset, gt_rx_reset, mac_rstn, link_up}), 32'hF0);
        checkOutput({tag, "_fail"}, 32'(qpll_fail_cnt), 32'd0);
        checkOutput({tag, "_drops"}, 32'(link_drop_cnt), 32'd0);
    endtask

    task automatic wait_link_all(input logic [1:0] level, input int budget, input string tag);
        int n = 0;
        while (link_up !== level && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(link_up), 32'(level));
    endtask

    task automatic wait_link(input int p, input logic level, input int budget, input string tag);
        int n = 0;
        while (link_up[p] !== level && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(link_up[p]), 32'(level));
    endtask

    initial begin
        int L;
        int d;
        int ntimeout;

        applyStimulus(1'b0, 1'b0, 2'b00);
        #23;
        check_reset_values("rst");
        sys_rstn = 1'b1;
        tick();
        tick();
        checkOutput("idle_hold", 32'(qpll_reset), 32'd1);

        // Nominal bring-up
        applyStimulus(1'b1, 1'b0, 2'b11);
        repeat (1 + QRST - 1) tick();
        checkOutput("qrst_hold", 32'(qpll_reset), 32'd1);
        tick();
        checkOutput("qrst_release", 32'(qpll_reset), 32'd0);
        d = $urandom_range(3, 40);
        repeat (d) tick();
        checkOutput("ready_before_lock", 32'(qpll_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 2'b11);
        repeat (SYNC) tick();
        checkOutput("ready_sync_lat", 32'(qpll_ready), 32'd0);
        tick();
        checkOutput("ready_rise", 32'(qpll_ready), 32'd1);
        repeat (GTRST) tick();
        checkOutput("gt_rst_hold", 32'({gt_tx_reset, gt_rx_reset}), 32'hF);
        tick();
        checkOutput("gt_rst_release", 32'({gt_tx_reset, gt_rx_reset}), 32'h0);
        wait_link_all(2'b11, 200, "bringup_link");
        checkOutput("bringup_mac", 32'(mac_rstn), 32'h3);
        check_counters("bringup");

        // Debounce rounds on port 0: first exactly below and at the threshold, then random
        for (int r = 0; r < 8; r++) begin
            L = (r == 0) ? DEB - 1 : (r == 1) ? DEB : $urandom_range(1, 14);
            applyStimulus(1'b1, 1'b1, 2'b10);
            for (int t = 1; t <= L + 10; t++) begin
                tick();
                if (t == L) applyStimulus(1'b1, 1'b1, 2'b11);
                checkOutput($sformatf("deb_L%0d_t%0d", L, t), 32'(link_up), 32'({1'b1, exp_link0(t, L)}));
            end
            if (L >= DEB) exp_drop[0]++;
            check_counters($sformatf("deb_L%0d", L));
        end

        // QPLL lock loss
        applyStimulus(1'b1, 1'b0, 2'b11);
        repeat (SYNC) tick();
        checkOutput("qloss_ready_hold", 32'(qpll_ready), 32'd1);
        tick();
        checkOutput("qloss_ready_fall", 32'(qpll_ready), 32'd0);
        checkOutput("qloss_qrst", 32'(qpll_reset), 32'd1);
        checkOutput("qloss_link_hold", 32'(link_up), 32'h3);
        tick();
        checkOutput("qloss_ports", 32'({gt_tx_reset, gt_rx_reset, mac_rstn, link_up}), 32'hF0);
        d = $urandom_range(2, 20);
        repeat (d) tick();
        applyStimulus(1'b1, 1'b1, 2'b11);
        wait_link_all(2'b11, 300, "qloss_recover");
        check_counters("qloss");

        // Saturating drop counter on port 1
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01);
            wait_link(1, 1'b0, 40, "sat_drop");
            applyStimulus(1'b1, 1'b1, 2'b11);
            wait_link(1, 1'b1, 40, "sat_relink");
            if (exp_drop[1] < 255) exp_drop[1]++;
            if (i == 254 || i == 299) begin
                checkOutput($sformatf("sat_cnt_%0d", i + 1), 32'(drop_of(1)), 32'(exp_drop[1]));
            end
        end
        checkOutput("sat_port0_link", 32'(link_up[0]), 32'd1);
        check_counters("sat");

        // Enable removed while port 0 is in its MAC reset phase
        applyStimulus(1'b1, 1'b1, 2'b10);
        for (int t = 1; t <= SYNC + DEB + 2; t++) begin
            tick();
            if (t == DEB) applyStimulus(1'b1, 1'b1, 2'b11);
        end
        exp_drop[0]++;
        checkOutput("en_mac_phase", 32'({mac_rstn, link_up}), 32'hA);
        applyStimulus(1'b0, 1'b1, 2'b11);
        tick();
        checkOutput("en_off_qrst", 32'({qpll_reset, qpll_ready}), 32'h2);
        checkOutput("en_off_link_hold", 32'(link_up), 32'h2);
        tick();
        checkOutput("en_off_ports", 32'({gt_tx_reset, gt_rx_reset, mac_rstn, link_up}), 32'hF0);
        repeat (5) tick();
        checkOutput("en_off_idle", 32'(qpll_reset), 32'd1);
        check_counters("en_off");
        applyStimulus(1'b1, 1'b1, 2'b11);
        wait_link_all(2'b11, 300, "en_reup");

        // Asynchronous reset between clock edges
        tick();
        #2;
        sys_rstn = 1'b0;
        #1;
        exp_fail = 0;
        exp_drop[0] = 0;
        exp_drop[1] = 0;
        check_reset_values("async_rst");

        // QPLL lock timeouts
        applyStimulus(1'b0, 1'b0, 2'b11);
        tick();
        sys_rstn = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 2'b11);
        ntimeout = $urandom_range(3, 5);
        tick();
        for (int k = 1; k <= ntimeout; k++) begin
            repeat (QRST + LTO - 1) tick();
            checkOutput($sformatf("to_before_%0d", k), 32'({qpll_reset, qpll_fail_cnt}), 32'({1'b0, 8'(exp_fail)}));
            tick();
            exp_fail++;
            checkOutput($sformatf("to_after_%0d", k), 32'({qpll_reset, qpll_fail_cnt}), 32'({1'b1, 8'(exp_fail)}));
        end
        d = $urandom_range(0, 40);
        repeat (d) tick();
        applyStimulus(1'b1, 1'b1, 2'b11);
        wait_link_all(2'b11, 400, "to_bringup");
        check_counters("to_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
